// File: rtl/sr_latch_sync.sv
// Bank of independent synchronous SR flip-flops with a selectable policy for
// simultaneous set/reset, sticky per-cell conflict flags and change pulses.
module sr_latch_sync #(
  parameter int               WIDTH         = 1,
  parameter int               CONFLICT_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] conflict,
  input  logic             conflict_clr,
  output logic [WIDTH-1:0] changed
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] conflict_reg;
  logic [WIDTH-1:0] conflict_next;
  logic [WIDTH-1:0] changed_reg;
  logic [WIDTH-1:0] changed_next;
  logic [WIDTH-1:0] both_value;

  // Value a cell takes when set and clear arrive together; unknown modes hold.
  generate
    if (CONFLICT_MODE == 1) begin : g_set_wins
      assign both_value = '1;
    end else if (CONFLICT_MODE == 2) begin : g_reset_wins
      assign both_value = '0;
    end else if (CONFLICT_MODE == 3) begin : g_toggle
      assign both_value = ~q_reg;
    end else begin : g_hold
      assign both_value = q_reg;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      assign q_next[gi] = (s[gi] && r[gi])  ? both_value[gi] :
                          s[gi]             ? 1'b1 :
                          r[gi]             ? 1'b0 :
                                              q_reg[gi];
    end
  endgenerate

  // A fresh conflict outranks a clear arriving on the same edge.
  assign conflict_next = (conflict_reg & ~{WIDTH{conflict_clr}}) | (s & r);
  assign changed_next  = q_next ^ q_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg        <= RESET_VALUE;
      conflict_reg <= '0;
      changed_reg  <= '0;
    end else begin
      q_reg        <= q_next;
      conflict_reg <= conflict_next;
      changed_reg  <= changed_next;
    end
  end

  assign q        = q_reg;
  assign q_n      = ~q_reg;
  assign conflict = conflict_reg;
  assign changed  = changed_reg;

endmodule

// File: tb/tb_sr_latch_sync.sv
// Four 4-bit instances, one per conflict policy, share stimulus; a per-bit
// reference model feeds a queue that an edge-driven monitor drains and checks.
module tb_sr_latch_sync;

  localparam int         NDUT = 4;
  localparam logic [3:0] RV   = 4'b1010;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] s = '0;
  logic [3:0] r = '0;
  logic       conflict_clr = 1'b0;
  logic [3:0] q_w [NDUT];
  logic [3:0] qn_w [NDUT];
  logic [3:0] cf_w [NDUT];
  logic [3:0] ch_w [NDUT];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      sr_latch_sync #(.WIDTH(4), .CONFLICT_MODE(gi), .RESET_VALUE(RV)) dut (
        .clk(clk), .reset(reset), .s(s), .r(r),
        .q(q_w[gi]), .q_n(qn_w[gi]), .conflict(cf_w[gi]),
        .conflict_clr(conflict_clr), .changed(ch_w[gi])
      );
    end
  endgenerate

  typedef struct {
    int unsigned q  [NDUT];
    int unsigned cf [NDUT];
    int unsigned ch [NDUT];
  } exp_t;

  exp_t        sb [$];
  int unsigned m_q  [NDUT];
  int unsigned m_cf [NDUT];
  int unsigned m_ch [NDUT];
  int          vectors = 0;
  int          miscompares = 0;
  bit          done = 1'b0;

  // Reference: each cell evaluated as a truth-table lookup on its own bit.
  function automatic int unsigned cell_next(int mode, int sv, int rv, int qv);
    if (sv == 1 && rv == 0) return 1;
    if (sv == 0 && rv == 1) return 0;
    if (sv == 0 && rv == 0) return qv;
    case (mode)
      1:       return 1;
      2:       return 0;
      3:       return 1 - qv;
      default: return qv;
    endcase
  endfunction

  task automatic step(input logic rst, input logic [3:0] sv, input logic [3:0] rv,
                      input logic clr);
    exp_t e;
    @(negedge clk);
    reset = rst; s = sv; r = rv; conflict_clr = clr;
    for (int d = 0; d < NDUT; d++) begin
      if (rst) begin
        m_q[d] = RV; m_cf[d] = 0; m_ch[d] = 0;
      end else begin
        int unsigned nq = 0, ncf = 0, nch = 0;
        for (int b = 0; b < 4; b++) begin
          int qb  = (m_q[d] >> b) & 1;
          int cfb = (m_cf[d] >> b) & 1;
          int nb  = cell_next(d, sv[b], rv[b], qb);
          nq  += nb << b;
          if (nb != qb) nch += 1 << b;
          if ((cfb == 1 && !clr) || (sv[b] && rv[b])) ncf += 1 << b;
        end
        m_q[d] = nq; m_cf[d] = ncf; m_ch[d] = nch;
      end
      e.q[d] = m_q[d]; e.cf[d] = m_cf[d]; e.ch[d] = m_ch[d];
    end
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int d, input logic [3:0] act,
                       input int unsigned req);
    vectors++;
    if (act !== req[3:0]) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %b expected %b", name, d, act, req[3:0]);
    end
  endtask

  // Monitor: every edge after stimulus starts, one expected entry is due.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int d = 0; d < NDUT; d++) begin
          check("q", d, q_w[d], e.q[d]);
          check("q_n", d, qn_w[d], (~e.q[d]) & 4'hF);
          check("conflict", d, cf_w[d], e.cf[d]);
          check("changed", d, ch_w[d], e.ch[d]);
        end
      end
    end
  end

  initial begin
    // Reset while setting bit 0: reset wins, q = RESET_VALUE.
    step(1'b1, 4'b0001, 4'b0000, 1'b0);
    step(1'b0, 4'b0001, 4'b0000, 1'b0);   // bit0 rises, changed pulse
    step(1'b0, 4'b0001, 4'b0000, 1'b0);   // already 1, no pulse
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 4'b0001, 1'b0);   // clear bit0
    step(1'b0, 4'b0001, 4'b0001, 1'b0);   // conflict from q=0, per policy
    step(1'b0, 4'b0001, 4'b0001, 1'b0);   // toggle mode flips back
    step(1'b0, 4'b0000, 4'b0000, 1'b0);   // conflict sticky
    step(1'b0, 4'b0000, 4'b0000, 1'b1);   // clear conflicts
    step(1'b0, 4'b1111, 4'b1111, 1'b1);   // new conflict beats clear
    step(1'b0, 4'b0000, 4'b0000, 1'b1);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 4'b0101, 4'b1000, 1'b0);   // q 1010 -> 0111, changed 1101
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 7) == 0));
    end
    @(negedge clk);
    reset = 1'b0; s = '0; r = '0; conflict_clr = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: bench did not finish, expected completion");
      $fatal(1, "timeout");
    end
  end

endmodule
